saed32_port_ctrl: RTL and testbench

SAED32_PORT_CTRL -- requirements
Module: saed32_port_ctrl

---
 rtl/saed32_mem_pkg.sv | 29 ++
 rtl/saed32_secded.sv | 48 ++++
 rtl/saed32_port_ctrl.sv | 125 ++++++++++++
 tb/tb_saed32_port_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saed32_mem_pkg.sv
// Shared widths, FSM state type and Hamming position helper for the SAED32 port controller.
package saed32_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CHK_W      = 7;
    localparam int unsigned MEM_W_DEF  = DATA_W_DEF + CHK_W;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Hamming code position of data bit idx: the idx-th position that is not a power of two.
    function automatic logic [CHK_W-2:0] hamming_pos(input int unsigned idx);
        int unsigned      cnt;
        logic [CHK_W-2:0] pos;
        cnt = 0;
        pos = '0;
        for (int unsigned p = 3; p < (32'd1 << (CHK_W - 1)); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p[CHK_W-2:0];
                cnt++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/saed32_secded.sv
// Combinational SECDED encode and decode/correct for 32 data bits plus 7 check bits.
module saed32_secded
    import saed32_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MEM_W  = MEM_W_DEF
) (
    input  logic [DATA_W-1:0] enc_data,
    output logic [MEM_W-1:0]  enc_code,
    input  logic [MEM_W-1:0]  dec_code,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_err_corr,
    output logic              dec_err_uncorr
);

    localparam int SYN_W = MEM_W - DATA_W - 1;

    logic [SYN_W-1:0] enc_chk;
    logic [SYN_W-1:0] dec_syn;
    logic             dec_par;

    function automatic logic [SYN_W-1:0] hamming_chk(input logic [DATA_W-1:0] d);
        logic [SYN_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (d[i]) c ^= hamming_pos(i);
        end
        return c;
    endfunction

    // Word layout: {overall parity, hamming checks, data}; all-zero data encodes to all-zero.
    always_comb begin
        enc_chk  = hamming_chk(enc_data);
        enc_code = {^{enc_chk, enc_data}, enc_chk, enc_data};
    end

    always_comb begin
        dec_syn  = hamming_chk(dec_code[DATA_W-1:0]) ^ dec_code[MEM_W-2:DATA_W];
        dec_par  = ^dec_code;
        dec_data = dec_code[DATA_W-1:0];
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (dec_par && (dec_syn == hamming_pos(i))) dec_data[i] = ~dec_code[i];
        end
        dec_err_corr   = dec_par;
        dec_err_uncorr = ~dec_par & (|dec_syn);
    end

endmodule

// File: rtl/saed32_port_ctrl.sv
// Single-port controller for a 32x39 SRAM: post-reset clear sweep, then request/response access.
// Optional SECDED protection is enabled with the SAED32_PORT_CTRL_ECC_EN macro.
module saed32_port_ctrl
    import saed32_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MEM_W  = MEM_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err_corr,
    output logic              rsp_err_uncorr,
    output logic              init_done,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [MEM_W-1:0]  mem_d,
    output logic [MEM_W-1:0]  mem_wem,
    input  logic [MEM_W-1:0]  mem_q
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rd_inflight_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_corr_q;
    logic              rsp_err_uncorr_q;
    logic              accept;
    logic [MEM_W-1:0]  enc_word;
    logic [DATA_W-1:0] dec_data;
    logic              dec_corr;
    logic              dec_uncorr;

`ifdef SAED32_PORT_CTRL_ECC_EN
    saed32_secded #(
        .DATA_W(DATA_W),
        .MEM_W (MEM_W)
    ) u_secded (
        .enc_data      (req_wdata),
        .enc_code      (enc_word),
        .dec_code      (mem_q),
        .dec_data      (dec_data),
        .dec_err_corr  (dec_corr),
        .dec_err_uncorr(dec_uncorr)
    );
`else
    logic unused_chk;
    assign enc_word   = {{(MEM_W - DATA_W){1'b0}}, req_wdata};
    assign dec_data   = mem_q[DATA_W-1:0];
    assign dec_corr   = 1'b0;
    assign dec_uncorr = 1'b0;
    assign unused_chk = ^mem_q[MEM_W-1:DATA_W];
`endif

    // A stalled response or an outstanding read blocks new requests.
    assign req_ready = (state_q == ST_RUN) & ~rd_inflight_q & ~(rsp_valid_q & ~rsp_ready);
    assign accept    = req_valid & req_ready;
    assign mem_wem   = '1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_ce  = 1'b0;
        mem_we  = 1'b0;
        mem_a   = req_addr;
        mem_d   = enc_word;
        unique case (state_q)
            ST_INIT: begin
                mem_ce = 1'b1;
                mem_we = 1'b1;
                mem_a  = cnt_q;
                mem_d  = '0;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) state_d = ST_RUN;
            end
            ST_RUN: begin
                mem_ce = accept;
                mem_we = accept & req_we;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= ST_INIT;
            cnt_q            <= '0;
            rd_inflight_q    <= 1'b0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_err_corr_q   <= 1'b0;
            rsp_err_uncorr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_inflight_q <= accept & ~req_we;
            if (rd_inflight_q) begin
                rsp_valid_q      <= 1'b1;
                rsp_rdata_q      <= dec_data;
                rsp_err_corr_q   <= dec_corr;
                rsp_err_uncorr_q <= dec_uncorr;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err_corr   = rsp_err_corr_q;
    assign rsp_err_uncorr = rsp_err_uncorr_q;
    assign init_done      = (state_q == ST_RUN);

endmodule

// File: tb/tb_saed32_port_ctrl.sv
// Scoreboard bench for saed32_port_ctrl with a behavioural SRAM and reference memory model.
module tb_saed32_port_ctrl;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int MW    = 39;
    localparam int DEPTH = 32;

    logic          CLK;
    logic          RST;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err_corr;
    logic          rsp_err_uncorr;
    logic          init_done;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [MW-1:0] mem_d;
    logic [MW-1:0] mem_wem;
    logic [MW-1:0] mem_q;

    saed32_port_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MEM_W (MW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err_corr  (rsp_err_corr),
        .rsp_err_uncorr(rsp_err_uncorr),
        .init_done     (init_done),
        .mem_ce        (mem_ce),
        .mem_we        (mem_we),
        .mem_a         (mem_a),
        .mem_d         (mem_d),
        .mem_wem       (mem_wem),
        .mem_q         (mem_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural SRAM; inj_mask corrupts read data to emulate stored bit errors.
    logic [MW-1:0] sram [DEPTH];
    logic [MW-1:0] sram_q;
    logic [MW-1:0] inj_mask;
    logic          fill_garbage;

    always @(posedge CLK) begin
        if (fill_garbage) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= MW'({$urandom(), $urandom()});
        end else if (mem_ce === 1'b1) begin
            if (mem_we) sram[mem_a] <= (sram[mem_a] & ~mem_wem) | (mem_d & mem_wem);
            else        sram_q      <= sram[mem_a] ^ inj_mask;
        end
    end
    assign mem_q = sram_q;

    // rsp_ready driver: random or fixed, updated 2 time units after each rising edge.
    logic rr_random;
    logic rr_fixed;
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            rsp_ready = rr_random ? 1'($urandom_range(0, 1)) : rr_fixed;
        end
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          corr;
        logic          uncorr;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            checks;
    int            errors;
    int            wem_bad;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: pops an expectation on every response handshake and checks hold-while-stalled.
    logic          prev_stall;
    logic [DW-1:0] held_data;
    logic [1:0]    held_flags;
    initial begin
        exp_t e;
        prev_stall = 1'b0;
        forever begin
            @(negedge CLK);
            if (mem_wem !== '1) wem_bad++;
            if (RST) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", rsp_valid, 1'b1);
                    check("hold_data", rsp_rdata, held_data);
                    check("hold_flags", {rsp_err_corr, rsp_err_uncorr}, held_flags);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: got data 0x%0h, expected no response",
                                 rsp_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_rdata, e.data);
                        check("rsp_err_corr", rsp_err_corr, e.corr);
                        check("rsp_err_uncorr", rsp_err_uncorr, e.uncorr);
                    end
                end
                prev_stall = rsp_valid && !rsp_ready;
                held_data  = rsp_rdata;
                held_flags = {rsp_err_corr, rsp_err_uncorr};
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, update the reference model.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         output int waited);
        exp_t e;
        int   flips;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        waited    = 0;
        @(negedge CLK);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge CLK);
        end
        check("req_accept", req_ready, 1'b1);
        if (req_ready) begin
            @(posedge CLK);
            if (we) begin
                ref_mem[addr] = data;
            end else begin
                flips    = $countones(inj_mask);
                e.data   = (flips >= 2) ? (ref_mem[addr] ^ inj_mask[DW-1:0]) : ref_mem[addr];
                e.corr   = (flips == 1);
                e.uncorr = (flips >= 2);
                exp_q.push_back(e);
            end
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Releases reset after one more reset edge and checks the 32-cycle clearing sweep.
    task automatic release_and_sweep();
        int bad;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge CLK);
            if (req_ready !== 1'b0 || mem_ce !== 1'b1 || mem_we !== 1'b1 ||
                mem_a !== AW'(k) || mem_d !== '0 || init_done !== 1'b0 ||
                rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err_corr !== 1'b0 ||
                rsp_err_uncorr !== 1'b0) bad++;
        end
        check("sweep_bad_cycles", bad, 0);
        @(negedge CLK);
        check("init_done_after_sweep", init_done, 1'b1);
        check("ready_after_sweep", req_ready, 1'b1);
        check("idle_mem_ce", mem_ce, 1'b0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int sum;
        checks       = 0;
        errors       = 0;
        wem_bad      = 0;
        RST          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        inj_mask     = '0;
        rr_random    = 1'b0;
        rr_fixed     = 1'b1;
        fill_garbage = 1'b1;
        @(posedge CLK);
        #1;
        fill_garbage = 1'b0;
        @(negedge CLK);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_err_flags", {rsp_err_corr, rsp_err_uncorr}, 2'b00);
        check("rst_init_done", init_done, 1'b0);
        release_and_sweep();

        // Write then read with response-latency check.
        issue(1'b1, 5'd5, 32'hDEADBEEF, w);
        issue(1'b0, 5'd5, 32'h0, w);
        @(negedge CLK);
        check("rsp_latency_t1", rsp_valid, 1'b0);
        @(negedge CLK);
        check("rsp_latency_t2", rsp_valid, 1'b1);
        @(posedge CLK);
        #1;
        drain();

        // Back-to-back writes sustain one per cycle; reads one per two cycles.
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, AW'(10 + i), $urandom(), w);
            sum += w;
        end
        check("write_b2b_stalls", sum, 0);
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, AW'(10 + i), 32'h0, w);
            sum += w;
        end
        check("read_b2b_stalls", sum, 2);
        drain();

        // Read of an address written the previous cycle.
        issue(1'b1, 5'd7, 32'hA5C3_0F71, w);
        issue(1'b0, 5'd7, 32'h0, w);
        check("raw_read_no_stall", w, 0);
        drain();

        // Response stalled by rsp_ready=0 for four cycles.
        rr_fixed = 1'b0;
        idle(2);
        issue(1'b0, 5'd5, 32'h0, w);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_req_ready", req_ready, 1'b0);
            check("stall_rsp_rdata", rsp_rdata, ref_mem[5]);
        end
        @(posedge CLK);
        #1;
        rr_fixed = 1'b1;
        idle(1);
        issue(1'b0, 5'd7, 32'h0, w);
        check("resume_after_stall", w, 0);
        drain();

`ifdef SAED32_PORT_CTRL_ECC_EN
        issue(1'b1, 5'd9, 32'h12345678, w);
        inj_mask = MW'(1) << 3;
        issue(1'b0, 5'd9, 32'h0, w);
        drain();
        inj_mask = (MW'(1) << 3) | (MW'(1) << 9);
        issue(1'b0, 5'd9, 32'h0, w);
        drain();
        inj_mask = MW'(1) << 35;
        issue(1'b0, 5'd9, 32'h0, w);
        drain();
        inj_mask = '0;
`endif

        // Randomised mix with random response back-pressure.
        rr_random = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom(), w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rr_random = 1'b0;
        rr_fixed  = 1'b1;
        idle(2);
        drain();

        // Reset while a read is in flight: response discarded, sweep restarts.
        issue(1'b1, 5'd3, 32'h0BAD_F00D, w);
        issue(1'b0, 5'd3, 32'h0, w);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_inflight_no_rsp", rsp_valid, 1'b0);
        release_and_sweep();
        issue(1'b0, 5'd3, 32'h0, w);
        issue(1'b0, 5'd5, 32'h0, w);
        drain();

        check("mem_wem_bad_cycles", wem_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
